// File: rtl/pcpu_hazard_unit.sv
// Hazard/forward/flush control beside ID over a DEPTH-slot write scoreboard; PCPU_FORWARD_EN builds in forwarding.
// Controls are combinational in the same cycle; scoreboard and stall counter step every rising edge, no backpressure.
module pcpu_hazard_unit #(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int RA_W     = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [RA_W-1:0]              id_rs,
  input  logic [RA_W-1:0]              id_rt,
  input  logic                         id_rs_used,
  input  logic                         id_rt_used,
  input  logic                         id_rf_we,
  input  logic [RA_W-1:0]              id_rf_dst,
  input  logic                         id_is_load,
  input  logic                         ex_branch_taken,
  input  logic                         cnt_clr,
  output logic                         if_stall,
  output logic                         id_hold,
  output logic                         id_flush,
  output logic                         ex_bubble,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_a_sel,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_b_sel,
  output logic [31:0]                  stall_cycles
);

  localparam int SEL_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] dst;
    logic            load;
  } sbEntry_t;

  sbEntry_t [DEPTH-1:0]  sb;
  sbEntry_t              newEntry;
  logic [DEPTH-1:0]      ready;
  logic [1:0][RA_W-1:0]  srcAddr;
  logic [1:0]            srcUsed;
  logic [1:0]            srcHaz;
  logic [1:0][SEL_W-1:0] srcSel;
  logic                  found;
  logic                  hazard;
  logic                  issue;

  // Index 0 is the A operand (rs), index 1 the B operand (rt).
  assign srcAddr = {id_rt, id_rs};
  assign srcUsed = {id_rt_used, id_rs_used};

  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = (i + 1) >= (sb[i].load ? LOAD_LAT : 1);
    end
  end

  // Scan from the youngest slot so the first match found is the one that counts.
  always_comb begin
    srcHaz = '0;
    srcSel = '0;
    found  = 1'b0;
    for (int s = 0; s < 2; s++) begin
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!found && srcUsed[s] && (srcAddr[s] != '0) && sb[i].v && (sb[i].dst == srcAddr[s])) begin
          found = 1'b1;
`ifdef PCPU_FORWARD_EN
          if (ready[i]) begin
            srcSel[s] = SEL_W'(i + 1);
          end else begin
            srcHaz[s] = 1'b1;
          end
`else
          srcHaz[s] = 1'b1;
`endif
        end
      end
    end
  end

`ifndef PCPU_FORWARD_EN
  logic unusedCfg;
  assign unusedCfg = ^ready;
`endif

  assign hazard    = id_valid & (|srcHaz);
  assign issue     = id_valid & ~hazard & ~ex_branch_taken;
  assign newEntry  = {issue & id_rf_we, id_rf_dst, id_is_load};

  assign if_stall  = hazard & ~ex_branch_taken;
  assign id_hold   = hazard & ~ex_branch_taken;
  assign id_flush  = ex_branch_taken;
  assign ex_bubble = hazard | ex_branch_taken;
  assign fwd_a_sel = srcSel[0];
  assign fwd_b_sel = srcSel[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb <= '0;
    end else begin
      sb[0] <= newEntry;
      for (int i = 1; i < DEPTH; i++) begin
        sb[i] <= sb[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (cnt_clr) begin
      stall_cycles <= '0;
    end else if (if_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pcpu_hazard_unit.sv
// Bench for pcpu_hazard_unit: directed scenarios then random traffic against a timestamped write-list model.
module tb_pcpu_hazard_unit;

  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 2;
  localparam int RA_W     = 5;
  localparam int SEL_W    = $clog2(DEPTH+1);
`ifdef PCPU_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             id_valid = 1'b0;
  logic [RA_W-1:0]  id_rs = '0;
  logic [RA_W-1:0]  id_rt = '0;
  logic             id_rs_used = 1'b0;
  logic             id_rt_used = 1'b0;
  logic             id_rf_we = 1'b0;
  logic [RA_W-1:0]  id_rf_dst = '0;
  logic             id_is_load = 1'b0;
  logic             ex_branch_taken = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             if_stall;
  logic             id_hold;
  logic             id_flush;
  logic             ex_bubble;
  logic [SEL_W-1:0] fwd_a_sel;
  logic [SEL_W-1:0] fwd_b_sel;
  logic [31:0]      stall_cycles;

  pcpu_hazard_unit #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rf_we(id_rf_we),
    .id_rf_dst(id_rf_dst), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
    .cnt_clr(cnt_clr), .if_stall(if_stall), .id_hold(id_hold), .id_flush(id_flush),
    .ex_bubble(ex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit v; logic [RA_W-1:0] rs; bit rsU; logic [RA_W-1:0] rt; bit rtU;
    bit we; logic [RA_W-1:0] dst; bit ld; bit br; bit clr;
  } in_t;

  // Reference: every issued write is remembered with the cycle it issued in.
  typedef struct { int cyc; logic [RA_W-1:0] dst; bit load; } wr_t;
  wr_t         inflight[$];
  int          now = 0;
  int          nPass = 0;
  int          nTotal = 0;
  logic [31:0] mCnt = '0;
  bit          expHaz = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTotal++;
    assert (got === exp) nPass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic in_t mk(bit v, int rs, bit rsU, int rt, bit rtU, bit we, int dst, bit ld, bit br, bit clr);
    in_t r;
    r.v = v; r.rs = RA_W'(rs); r.rsU = rsU; r.rt = RA_W'(rt); r.rtU = rtU;
    r.we = we; r.dst = RA_W'(dst); r.ld = ld; r.br = br; r.clr = clr;
    return r;
  endfunction

  function automatic in_t idle();              return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic in_t clrOp();             return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); endfunction
  function automatic in_t wr(int d, bit ld);   return mk(1, 0, 0, 0, 0, 1, d, ld, 0, 0); endfunction
  function automatic in_t rdA(int r);          return mk(1, r, 1, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic in_t rdB(int r);          return mk(1, 0, 0, r, 1, 0, 0, 0, 0, 0); endfunction

  // The youngest in-flight writer of s decides; its age equals the slot number plus one.
  function automatic void modelSrc(input logic [RA_W-1:0] s, input bit used, output bit haz, output int sel);
    int best; bit bestLoad; int age;
    best = 0; bestLoad = 0; haz = 0; sel = 0;
    foreach (inflight[k]) begin
      age = now - inflight[k].cyc;
      if (used && s != 0 && inflight[k].dst == s && age >= 1 && age <= DEPTH && (best == 0 || age < best)) begin
        best = age;
        bestLoad = inflight[k].load;
      end
    end
    if (best != 0) begin
      if (FWD && best >= (bestLoad ? LOAD_LAT : 1)) sel = best;
      else haz = 1;
    end
  endfunction

  task automatic setIn(input in_t x);
    @(negedge clk);
    id_valid = x.v; id_rs = x.rs; id_rs_used = x.rsU; id_rt = x.rt; id_rt_used = x.rtU;
    id_rf_we = x.we; id_rf_dst = x.dst; id_is_load = x.ld; ex_branch_taken = x.br; cnt_clr = x.clr;
    #1;
  endtask

  task automatic evalCheck(input string tag);
    bit hA, hB, st; int sA, sB;
    modelSrc(id_rs, id_rs_used, hA, sA);
    modelSrc(id_rt, id_rt_used, hB, sB);
    expHaz = id_valid & (hA | hB);
    st = expHaz & ~ex_branch_taken;
    chk({tag, ".if_stall"},  32'(if_stall),  32'(st));
    chk({tag, ".id_hold"},   32'(id_hold),   32'(st));
    chk({tag, ".id_flush"},  32'(id_flush),  32'(ex_branch_taken));
    chk({tag, ".ex_bubble"}, 32'(ex_bubble), 32'(expHaz | ex_branch_taken));
    chk({tag, ".fwd_a_sel"}, 32'(fwd_a_sel), sA);
    chk({tag, ".fwd_b_sel"}, 32'(fwd_b_sel), sB);
    chk({tag, ".stall_cycles"}, stall_cycles, mCnt);
  endtask

  task automatic advance();
    @(posedge clk);
    if (id_valid && !expHaz && !ex_branch_taken && id_rf_we)
      inflight.push_back('{cyc: now, dst: id_rf_dst, load: id_is_load});
    if (cnt_clr) mCnt = '0;
    else if (expHaz && !ex_branch_taken && mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 32'd1;
    now++;
    while (inflight.size() > 0 && now - inflight[0].cyc > DEPTH) void'(inflight.pop_front());
  endtask

  task automatic step(input string tag, input in_t x);
    setIn(x); evalCheck(tag); advance();
  endtask

  task automatic drain();
    repeat (DEPTH + 1) step("drain", idle());
  endtask

  // Holds the reader in ID until it stops stalling; returns with the reader still unclocked.
  task automatic stallRun(input string tag, input in_t x, output int n);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      setIn(x); evalCheck(tag);
      if (if_stall !== 1'b1) return;
      n++;
      advance();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    in_t x;

    // Reset state, with a branch to show id_flush still follows its input.
    setIn(idle()); evalCheck("reset");
    setIn(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); evalCheck("reset_br");
    @(negedge clk); rst = 1'b1;

    // ALU back-to-back.
    step("alu.clr", clrOp());
    step("alu.add", wr(3, 0));
    stallRun("alu.rd1", mk(1, 3, 1, 0, 0, 1, 4, 0, 0, 0), n);
    chk("alu.stall_n", n, FWD ? 0 : 3);
    chk("alu.sel1", 32'(fwd_a_sel), FWD ? 1 : 0);
    advance();
    setIn(rdA(3)); evalCheck("alu.rd2");
    chk("alu.sel2", 32'(fwd_a_sel), FWD ? 2 : 0);
    chk("alu.cnt", stall_cycles, FWD ? 0 : 3);
    advance();

    // Load-use.
    drain();
    step("ldu.clr", clrOp());
    step("ldu.lw", wr(5, 1));
    stallRun("ldu.rd", rdB(5), n);
    chk("ldu.stall_n", n, FWD ? 1 : 3);
    chk("ldu.selb", 32'(fwd_b_sel), FWD ? 2 : 0);
    advance();
    #1 chk("ldu.cnt", stall_cycles, FWD ? 1 : 3);

    // Register 0 and youngest-match priority.
    drain();
    step("r0.wr", wr(0, 0));
    setIn(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0)); evalCheck("r0.rd");
    chk("r0.stall", 32'(if_stall), 0);
    chk("r0.sel", 32'(fwd_a_sel), 0);
    advance();
    step("pri.wr_a", wr(7, 0));
    step("pri.wr_b", wr(7, 0));
    setIn(rdA(7)); evalCheck("pri.rd");
    chk("pri.sel", 32'(fwd_a_sel), FWD ? 1 : 0);
    chk("pri.stall", 32'(if_stall), FWD ? 0 : 1);
    advance();

    // Branch taken while a load-use stall is pending.
    drain();
    step("br.clr", clrOp());
    step("br.lw", wr(5, 1));
    setIn(mk(1, 0, 0, 5, 1, 1, 6, 0, 1, 0)); evalCheck("br.kill");
    chk("br.if_stall", 32'(if_stall), 0);
    chk("br.id_flush", 32'(id_flush), 1);
    chk("br.ex_bubble", 32'(ex_bubble), 1);
    advance();
    #1 chk("br.cnt", stall_cycles, 0);
    setIn(rdA(6)); evalCheck("br.noentry");
    chk("br.r6_stall", 32'(if_stall), 0);
    advance();

    // Counter saturation and clear.
    drain();
    #2 force dut.stall_cycles = 32'hFFFF_FFFE;
    #1 release dut.stall_cycles;
    mCnt = 32'hFFFF_FFFE;
    step("sat.lw1", wr(9, 1));
    stallRun("sat.rd1", rdB(9), n);
    advance();
    step("sat.lw2", wr(10, 1));
    stallRun("sat.rd2", rdB(10), n);
    chk("sat.stalled", 32'(n > 0), 1);
    advance();
    #1 chk("sat.hold", stall_cycles, 32'hFFFF_FFFF);
    step("sat.clr", clrOp());
    #1 chk("sat.cleared", stall_cycles, 0);

    // Asynchronous reset in the middle of a stall.
    drain();
    step("rst.lw", wr(5, 1));
    setIn(rdB(5)); evalCheck("rst.pre");
    chk("rst.stalling", 32'(if_stall), 1);
    #1 rst = 1'b0;
    #1;
    inflight.delete(); mCnt = '0;
    chk("rst.if_stall", 32'(if_stall), 0);
    chk("rst.id_hold", 32'(id_hold), 0);
    chk("rst.ex_bubble", 32'(ex_bubble), 0);
    chk("rst.fwd_b_sel", 32'(fwd_b_sel), 0);
    chk("rst.cnt", stall_cycles, 0);
    chk("rst.id_flush", 32'(id_flush), 0);
    @(negedge clk); rst = 1'b1;
    setIn(rdB(5)); evalCheck("rst.after");
    chk("rst.no_stall", 32'(if_stall), 0);
    advance();

    // Random traffic over a small register set to provoke frequent matches.
    for (int t = 0; t < 400; t++) begin
      x = mk($urandom_range(0, 99) < 85,
             $urandom_range(0, 3), $urandom_range(0, 99) < 70,
             $urandom_range(0, 3), $urandom_range(0, 99) < 50,
             $urandom_range(0, 99) < 60, $urandom_range(0, 3),
             $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
             $urandom_range(0, 99) < 3);
      step("rand", x);
    end

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
